ps2_wb_fifo: RTL and testbench
==============================

# ps2_wb_fifo

Wishbone-style PS/2 keyboard port with an on-chip scancode FIFO, status/control registers and an interrupt line. It is the next-generation keyboard I/O slave on the CPU I/O bus. It receives PS/2 frames directly in the `io_read_clk` domain, so there is no separate PS/2 clock. It buffers `DEPTH` scancodes, reports sticky error and overflow status, and lets software poll or take interrupts.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `TIMEOUT`, 5000: `io_read_clk` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `io_read_clk` in 1: the only clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `dat_i` in 32: write data.
- `adr_i` in 32: byte address; only `adr_i[3:2]` is decoded.
- `we_i` in 1: 1 = write, 0 = read.
- `stb_i` in 1: bus request.
- `dat_o` out 32: read data; registered.
- `ack_o` out 1: one-cycle acknowledge.
- `PS2_clk` in 1: raw PS/2 clock; asynchronous.
- `PS2_Data` in 1: raw PS/2 data; asynchronous.
- `irq` out 1: interrupt, level, registered.
- `key` out 8: last byte popped by a DATA read.
- `key_d` out 32: history of the last four popped bytes, newest in `[7:0]`.

## Operation
**Register map**
- `adr_i[3:2]`=0, DATA.
  - Read when FIFO is non-empty: `{23'b0, 1'b1, head}` and pop.
  - Read when empty: `0x000000AA`, no pop.
  - Writes ignored.
- `adr_i[3:2]`=1, STATUS.
  - Bit 0 `nonempty`, bit 1 `full`.
  - Bit 2 `overflow`, bit 3 `parity_err`, bit 4 `frame_err`; all three sticky.
  - `[15:8]` = entry count, 0..`DEPTH`.
  - Write: each 1 in `dat_i[4:2]` clears the corresponding sticky bit.
- `adr_i[3:2]`=2, CTRL.
  - Bit 0 `irq_en`, read/write.
  - Bit 1 `flush`, write-only and self-clearing; reads as 0.
- `adr_i[3:2]`=3, HIST: read returns `key_d`. Writes ignored.

**Bus handshake**
- `ack_o <= stb_i & ~ack_o`.
- A transaction takes effect on the edge where `stb_i && ack_o`. This covers pop, clear, CTRL write and flush.
- One transaction per strobe, even if `stb_i` is held high.

**Receiver**
- `PS2_clk` and `PS2_Data` each pass through a 2-flop synchroniser.
- A falling edge of the synchronised clock samples the synchronised data.
- The 11-bit frame is: start=0, 8 data bits LSB first, odd parity, stop=1. A 4-bit counter runs 0..10.
- Receiver states: IDLE → RECV on the first falling edge with data=0. A start bit of 1 is ignored and the receiver stays in IDLE.
- On bit 10 the receiver returns to IDLE and evaluates the frame:
  - Parity bad: set `parity_err`, discard the byte.
  - Stop bit 0: set `frame_err`, discard the byte.
  - Otherwise: push the byte.
- While in RECV, `TIMEOUT` cycles without a falling edge sets `frame_err` and returns to IDLE.

**FIFO**
- Circular buffer with `log2(DEPTH)`-bit read and write pointers that wrap, plus a separate count of `log2(DEPTH)+1` bits.
- Push while full, with no pop that cycle: the byte is dropped and `overflow` is set.
- Push and pop in the same cycle: both execute, count unchanged. This includes the full case, which does not set `overflow`.
- Flush: pointers and count go to 0. A push in the same cycle is dropped without setting `overflow`.
- On a pop: `key <= head`; `key_d <= {key_d[23:0], head}`.

**Interrupt**
- `irq <= irq_en & nonempty`, computed from post-update state.

## Timing
- Reset values: `dat_o`=0, `ack_o`=0, `irq`=0, `key`=0, `key_d`=0. Also FIFO empty, all sticky bits 0, `irq_en`=0, receiver in IDLE.
- Read latency:
  - `stb_i` is sampled high at edge N; `ack_o` and `dat_o` are valid in cycle N+1.
  - The pop and status update happen at edge N+1.
  - `ack_o` goes low after N+1.
- DATA/STATUS reads reflect state before that transaction's own pop.
- Push latency: the FIFO is updated 3–4 cycles after the 11th falling edge of the raw `PS2_clk` (2-flop sync plus edge detect plus push).
- `irq` changes on the edge after the FIFO/CTRL change that causes it.
- Reset mid-frame or mid-transaction aborts immediately to the reset state.

## Test plan
- Reset, then read DATA → `ack_o` for exactly one cycle, `dat_o`=`0x000000AA`. STATUS=0, `irq`=0.
- Send frame `0x1C` with good parity, then read DATA → `0x0000011C`. `key`=`0x1C`, `key_d`=`0x0000001C`; STATUS count returns to 0.
- `irq_en`=1, send 3 bytes `0x12,0xF0,0x12` → `irq` rises after the first push. Three DATA reads return them in order; `irq` drops after the third pop; HIST=`0x0012F012`.
- Push `DEPTH+1` frames with no reads → STATUS `full`=1, count=`DEPTH`, `overflow`=1, and the extra byte is lost. Write STATUS `0x4` → `overflow` clears, `full` stays 1.
- Frame with a bad parity bit → no push, `parity_err`=1. Abort after 5 bits, wait `TIMEOUT` cycles → `frame_err`=1. A following good frame is received correctly.
- With the FIFO full, a DATA read pop coincides with an incoming push → count stays `DEPTH`, no `overflow`. Then CTRL flush → count 0, `irq`=0 on the next cycle.

Source files
------------

// File: rtl/ps2_wb_fifo_if.sv
// ps2_wb_fifo_if: Wishbone-style slave bus between the CPU I/O fabric and the PS/2 keyboard port.
interface ps2_wb_fifo_if;
    logic [31:0] dat_i;
    logic [31:0] adr_i;
    logic        we_i;
    logic        stb_i;
    logic [31:0] dat_o;
    logic        ack_o;
    modport master (output dat_i, adr_i, we_i, stb_i, input dat_o, ack_o);
    modport slave  (input dat_i, adr_i, we_i, stb_i, output dat_o, ack_o);
endinterface

// File: rtl/ps2_wb_fifo.sv
// ps2_wb_fifo: PS/2 keyboard receiver feeding a scancode FIFO, with status/control registers and irq.
module ps2_wb_fifo #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 5000
) (
    input  logic                io_read_clk,
    input  logic                rst,
    ps2_wb_fifo_if.slave        bus,
    input  logic                PS2_clk,
    input  logic                PS2_Data,
    output logic                irq,
    output logic [7:0]          key,
    output logic [31:0]         key_d
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, RECV} rx_state_e;

    rx_state_e     state_q;
    logic [2:0]    c_q;
    logic [1:0]    d_q;
    logic [3:0]    bit_q;
    logic [8:0]    sr_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    rx_q;
    logic          push_q, perr_q, ferr_q, fall;

    assign fall = c_q[2] & ~c_q[1];

    // Sync flops reset high so the idle bus does not look like a falling edge.
    always_ff @(posedge io_read_clk or posedge rst) begin
        if (rst) begin
            c_q     <= '1;
            d_q     <= '1;
            state_q <= IDLE;
            bit_q   <= '0;
            sr_q    <= '0;
            tmo_q   <= '0;
            rx_q    <= '0;
            push_q  <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            c_q    <= {c_q[1:0], PS2_clk};
            d_q    <= {d_q[0], PS2_Data};
            push_q <= 1'b0;
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
            if (state_q == IDLE) begin
                tmo_q <= '0;
                if (fall && !d_q[1]) begin
                    state_q <= RECV;
                    bit_q   <= 4'd1;
                end
            end else if (fall) begin
                tmo_q <= '0;
                bit_q <= bit_q + 4'd1;
                if (bit_q == 4'd10) begin
                    state_q <= IDLE;
                    rx_q    <= sr_q[7:0];
                    if (!(^sr_q)) perr_q <= 1'b1;
                    else if (!d_q[1]) ferr_q <= 1'b1;
                    else push_q <= 1'b1;
                end else begin
                    sr_q <= {d_q[1], sr_q[8:1]};
                end
            end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_q <= IDLE;
                ferr_q  <= 1'b1;
            end else begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    logic [7:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0] cnt_q, cnt_d;
    logic [31:0] dat_q, hist_q, rd_data;
    logic [7:0]  key_q;
    logic [2:0]  clr;
    logic [1:0]  sel;
    logic        ack_q, ovf_q, perr_st_q, ferr_st_q, irq_en_q, irq_en_d, irq_q;
    logic        txn, wr, pop, flush, push_ok, ovf_set, full, nonempty;
    logic        unused;

    assign unused = ^{bus.adr_i[31:4], bus.adr_i[1:0], bus.dat_i[31:5]};

    // A DATA pop only happens if the presented word carried a byte (bit 8).
    always_comb begin
        sel      = bus.adr_i[3:2];
        txn      = bus.stb_i & ack_q;
        wr       = txn & bus.we_i;
        full     = cnt_q == (AW+1)'(DEPTH);
        nonempty = |cnt_q;
        pop      = txn & ~bus.we_i & (sel == 2'd0) & dat_q[8];
        flush    = wr & (sel == 2'd2) & bus.dat_i[1];
        push_ok  = push_q & ~flush & (~full | pop);
        ovf_set  = push_q & ~flush & full & ~pop;
        clr      = (wr && sel == 2'd1) ? bus.dat_i[4:2] : 3'b000;
        irq_en_d = (wr && sel == 2'd2) ? bus.dat_i[0] : irq_en_q;
        cnt_d    = flush ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        rd_data  = sel == 2'd0 ? (nonempty ? {23'b0, 1'b1, mem_q[rptr_q]} : 32'h0000_00AA) :
                   sel == 2'd1 ? {16'b0, 8'(cnt_q), 3'b0, ferr_st_q, perr_st_q, ovf_q, full, nonempty} :
                   sel == 2'd2 ? {31'b0, irq_en_q} : hist_q;
    end

    always_ff @(posedge io_read_clk or posedge rst) begin
        if (rst) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            ovf_q     <= 1'b0;
            perr_st_q <= 1'b0;
            ferr_st_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            key_q     <= '0;
            hist_q    <= '0;
        end else begin
            ack_q     <= bus.stb_i & ~ack_q;
            if (bus.stb_i && !ack_q) dat_q <= rd_data;
            ovf_q     <= (ovf_q & ~clr[0]) | ovf_set;
            perr_st_q <= (perr_st_q & ~clr[1]) | perr_q;
            ferr_st_q <= (ferr_st_q & ~clr[2]) | ferr_q;
            irq_en_q  <= irq_en_d;
            cnt_q     <= cnt_d;
            irq_q     <= irq_en_d & (|cnt_d);
            wptr_q    <= flush ? '0 : wptr_q + AW'(push_ok);
            rptr_q    <= flush ? '0 : rptr_q + AW'(pop);
            if (pop) begin
                key_q  <= mem_q[rptr_q];
                hist_q <= {hist_q[23:0], mem_q[rptr_q]};
            end
        end
    end

    always_ff @(posedge io_read_clk) begin
        if (push_ok) mem_q[wptr_q] <= rx_q;
    end

    assign bus.dat_o = dat_q;
    assign bus.ack_o = ack_q;
    assign irq       = irq_q;
    assign key       = key_q;
    assign key_d     = hist_q;
endmodule

// File: tb/tb_ps2_wb_fifo.sv
// tb_ps2_wb_fifo: directed PS/2 frames and bus accesses; read data checked by a scoreboard monitor.
module tb_ps2_wb_fifo;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 200;

    logic        clk, rst, ps2_clk, ps2_data, irq;
    logic [7:0]  key;
    logic [31:0] key_d;
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    ps2_wb_fifo_if bus();

    ps2_wb_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .io_read_clk(clk),
        .rst(rst),
        .bus(bus),
        .PS2_clk(ps2_clk),
        .PS2_Data(ps2_data),
        .irq(irq),
        .key(key),
        .key_d(key_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.ack_o && !bus.we_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: got dat_o=%h with no expected read", bus.dat_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (bus.dat_o !== e) begin
                    errors++;
                    $display("FAIL sb_read adr=%0d: got %h expected %h", bus.adr_i[3:2], bus.dat_o, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ack();
        int n = 0;
        @(negedge clk);
        while (!bus.ack_o && n < 5) begin
            n++;
            @(negedge clk);
        end
        if (!bus.ack_o) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got ack_o=0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
        @(posedge clk);
        #1;
        bus.adr_i = {28'b0, a, 2'b00};
        bus.we_i  = 1'b0;
        bus.stb_i = 1'b1;
        exp_q.push_back(exp);
        wait_ack();
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.adr_i = {28'b0, a, 2'b00};
        bus.dat_i = d;
        bus.we_i  = 1'b1;
        bus.stb_i = 1'b1;
        wait_ack();
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] bits;
        bits = {~bad_stop, bad_par ? ^b : ~^b, b, 1'b0};
        @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = bits[i];
            #40 ps2_clk = 1'b0;
            #40 ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.stb_i = 1'b0;
        bus.we_i  = 1'b0;
        bus.adr_i = '0;
        bus.dat_i = '0;
        do_reset();
        @(negedge clk);
        chk("rst_ack", {31'b0, bus.ack_o}, 32'd0);
        chk("rst_dat", bus.dat_o, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_key", {24'b0, key}, 32'd0);
        chk("rst_key_d", key_d, 32'd0);
        bus_read(2'd0, 32'h0000_00AA);
        @(negedge clk);
        chk("ack_one_cycle", {31'b0, bus.ack_o}, 32'd0);
        bus_read(2'd1, 32'h0000_0000);

        send_frame(8'h1C, 0, 0, 11);
        bus_read(2'd1, 32'h0000_0101);
        bus_read(2'd0, 32'h0000_011C);
        @(negedge clk);
        chk("key_1c", {24'b0, key}, 32'h1C);
        chk("key_d_1c", key_d, 32'h0000_001C);
        bus_read(2'd1, 32'h0000_0000);

        do_reset();
        bus_write(2'd2, 32'h1);
        @(negedge clk);
        chk("irq_empty", {31'b0, irq}, 32'd0);
        send_frame(8'h12, 0, 0, 11);
        chk("irq_rise", {31'b0, irq}, 32'd1);
        send_frame(8'hF0, 0, 0, 11);
        send_frame(8'h12, 0, 0, 11);
        bus_read(2'd0, 32'h0000_0112);
        bus_read(2'd0, 32'h0000_01F0);
        @(negedge clk);
        chk("irq_hold", {31'b0, irq}, 32'd1);
        bus_read(2'd0, 32'h0000_0112);
        @(negedge clk);
        chk("irq_drop", {31'b0, irq}, 32'd0);
        chk("key_12", {24'b0, key}, 32'h12);
        chk("key_d_hist", key_d, 32'h0012_F012);
        bus_read(2'd3, 32'h0012_F012);
        bus_read(2'd2, 32'h0000_0001);

        do_reset();
        send_frame(8'h55, 1, 0, 11);
        bus_read(2'd1, 32'h0000_0008);
        bus_write(2'd1, 32'h8);
        send_frame(8'h66, 0, 1, 11);
        bus_read(2'd1, 32'h0000_0010);
        bus_write(2'd1, 32'h10);
        bus_read(2'd1, 32'h0000_0000);
        send_frame(8'h77, 0, 0, 5);
        repeat (TIMEOUT + 20) @(posedge clk);
        bus_read(2'd1, 32'h0000_0010);
        send_frame(8'hA5, 0, 0, 11);
        bus_read(2'd1, 32'h0000_0111);
        bus_read(2'd0, 32'h0000_01A5);
        bus_write(2'd1, 32'h1C);
        bus_read(2'd1, 32'h0000_0000);

        do_reset();
        for (int i = 0; i <= DEPTH; i++) send_frame(8'h20 + 8'(i), 0, 0, 11);
        bus_read(2'd1, 32'h0000_1007);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, 32'h0000_1003);
        fork
            send_frame(8'h5A, 0, 0, 11);
            begin
                repeat (11) @(negedge ps2_clk);
                @(posedge clk);
                bus_read(2'd0, 32'h0000_0120);
            end
        join
        bus_read(2'd1, 32'h0000_1003);
        bus_read(2'd0, 32'h0000_0121);
        bus_read(2'd1, 32'h0000_0F01);
        bus_write(2'd2, 32'h1);
        repeat (2) @(negedge clk);
        chk("irq_full", {31'b0, irq}, 32'd1);
        bus_write(2'd2, 32'h3);
        repeat (2) @(negedge clk);
        chk("irq_flush", {31'b0, irq}, 32'd0);
        bus_read(2'd1, 32'h0000_0000);
        bus_read(2'd2, 32'h0000_0001);
        bus_read(2'd0, 32'h0000_00AA);

        repeat (5) @(negedge clk);
        chk("sb_drain", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
